// File: rtl/demux4_stream_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// The counter width default exists only when DEMUX4_COUNT_EN is defined.
package demux4_stream_pkg;

  localparam int DEF_WIDTH = 4;
`ifdef DEMUX4_COUNT_EN
  localparam int DEF_CNT_W = 8;
`endif

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux4_slot.sv
// One-entry holding register with load/ready handshake for a single output channel.
// Optional accepted-beat counter is built when DEMUX4_COUNT_EN is defined.
module demux4_slot
  import demux4_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef DEMUX4_COUNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             free,
  output logic [WIDTH-1:0] data,
  output slot_state_t      state
`ifdef DEMUX4_COUNT_EN
  , output logic [CNT_W-1:0] cnt
`endif
);

  // Valid/ready: a held beat leaves on any cycle where the slot is FULL and
  // ready is high; ready while EMPTY is ignored. A load is only issued when
  // free is high, so a FULL slot reloading in the same cycle never drops a beat.
  assign free = (state == SLOT_EMPTY) | ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      data  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (load) begin
            state <= SLOT_FULL;
            data  <= load_data;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            data <= load_data;
          end else if (ready) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

`ifdef DEMUX4_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer: each accepted beat goes to the slot picked by sel.
// Define DEMUX4_COUNT_EN to add per-channel accepted-beat counters (cnt_a..cnt_d).
module demux4_stream
  import demux4_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef DEMUX4_COUNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready
`ifdef DEMUX4_COUNT_EN
  , output logic [CNT_W-1:0] cnt_a
  , output logic [CNT_W-1:0] cnt_b
  , output logic [CNT_W-1:0] cnt_c
  , output logic [CNT_W-1:0] cnt_d
`endif
);

  slot_state_t      st    [4];
  logic [WIDTH-1:0] dq    [4];
  logic [3:0]       free;
  logic [3:0]       ready_v;
  logic [3:0]       load_v;
`ifdef DEMUX4_COUNT_EN
  logic [CNT_W-1:0] cq    [4];
`endif

  assign ready_v = {d_ready, c_ready, b_ready, a_ready};

  // in_ready looks only at the selected slot, never at in_valid, so a stalled
  // neighbour cannot block traffic to a free channel.
  always_comb begin
    in_ready = 1'b0;
    case (sel)
      CH_A:    in_ready = free[CH_A];
      CH_B:    in_ready = free[CH_B];
      CH_C:    in_ready = free[CH_C];
      CH_D:    in_ready = free[CH_D];
      default: in_ready = 1'b0;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_slot
    assign load_v[i] = in_valid & in_ready & (sel == 2'(i));

    demux4_slot #(
      .WIDTH (WIDTH)
`ifdef DEMUX4_COUNT_EN
      , .CNT_W (CNT_W)
`endif
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load_v[i]),
      .load_data (in_data),
      .ready     (ready_v[i]),
      .free      (free[i]),
      .data      (dq[i]),
      .state     (st[i])
`ifdef DEMUX4_COUNT_EN
      , .cnt     (cq[i])
`endif
    );
  end

  assign a = dq[CH_A];
  assign b = dq[CH_B];
  assign c = dq[CH_C];
  assign d = dq[CH_D];

  assign a_valid = (st[CH_A] == SLOT_FULL);
  assign b_valid = (st[CH_B] == SLOT_FULL);
  assign c_valid = (st[CH_C] == SLOT_FULL);
  assign d_valid = (st[CH_D] == SLOT_FULL);

`ifdef DEMUX4_COUNT_EN
  assign cnt_a = cq[CH_A];
  assign cnt_b = cq[CH_B];
  assign cnt_c = cq[CH_C];
  assign cnt_d = cq[CH_D];
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed scenarios plus randomized traffic
// against a per-channel queue model. Counter checks are built with DEMUX4_COUNT_EN.
module tb_demux4_stream;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic [1:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c, d;
  logic         a_valid, b_valid, c_valid, d_valid;
  logic [3:0]   rdy;
`ifdef DEMUX4_COUNT_EN
  logic [7:0]   cnt_a, cnt_b, cnt_c, cnt_d;
  logic [7:0]   out_cnt [4];
`endif

  logic [W-1:0] out_d [4];
  logic [3:0]   out_v;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: each channel is a queue of at most one beat.
  logic [W-1:0] exp_q [4][$];
  logic [W-1:0] last_d [4];
  int           exp_cnt [4];

  demux4_stream dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .c_valid  (c_valid),
    .d_valid  (d_valid),
    .a_ready  (rdy[0]),
    .b_ready  (rdy[1]),
    .c_ready  (rdy[2]),
    .d_ready  (rdy[3])
`ifdef DEMUX4_COUNT_EN
    , .cnt_a  (cnt_a)
    , .cnt_b  (cnt_b)
    , .cnt_c  (cnt_c)
    , .cnt_d  (cnt_d)
`endif
  );

  always #5 clk = ~clk;

  assign out_d[0] = a;
  assign out_d[1] = b;
  assign out_d[2] = c;
  assign out_d[3] = d;
  assign out_v    = {d_valid, c_valid, b_valid, a_valid};
`ifdef DEMUX4_COUNT_EN
  assign out_cnt[0] = cnt_a;
  assign out_cnt[1] = cnt_b;
  assign out_cnt[2] = cnt_c;
  assign out_cnt[3] = cnt_d;
`endif

  // Driver: apply current inputs across one rising edge and advance the model.
  task automatic tick();
    bit acc;
    acc = in_valid && (exp_q[sel].size() == 0 || rdy[sel]);
    @(posedge clk);
    if (rst) begin
      for (int ch = 0; ch < 4; ch++) begin
        exp_q[ch].delete();
        last_d[ch]  = '0;
        exp_cnt[ch] = 0;
      end
    end else begin
      for (int ch = 0; ch < 4; ch++)
        if (exp_q[ch].size() != 0 && rdy[ch]) void'(exp_q[ch].pop_front());
      if (acc) begin
        exp_q[sel].push_back(in_data);
        last_d[sel]  = in_data;
        exp_cnt[sel] = exp_cnt[sel] + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [W-1:0] dat, input logic [1:0] s, input logic v);
    in_data  = dat;
    sel      = s;
    in_valid = v;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 4'hF;
    drive('0, 2'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      drive(4'hF, 2'(s), 1'b0);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_in_ready sel=%0d got %b want 1", s, in_ready);
      end
    end
    n_cmp++;
    if (out_v !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_valids got %b want 0000", out_v);
    end
    for (int ch = 0; ch < 4; ch++) begin
      n_cmp++;
      if (out_d[ch] !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_data ch=%0d got %h want 0", ch, out_d[ch]);
      end
    end
  endtask

  task automatic test_single_c();
    rdy = 4'hF;
    drive(4'h5, 2'd2, 1'b1);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_in_ready got %b want 1", in_ready);
    end
    tick();
    drive(4'h0, 2'd0, 1'b0);
    n_cmp++;
    if (c !== 4'h5 || out_v !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_c got c=%h valids=%b want c=5 valids=0100", c, out_v);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_in_ready_after got %b want 1", in_ready);
    end
    tick();
    n_cmp++;
    if (out_v !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_drain got valids=%b want 0000", out_v);
    end
  endtask

  task automatic test_stall_d();
    rdy = 4'b0111;
    drive(4'h9, 2'd3, 1'b1);
    tick();
    n_cmp++;
    if (d !== 4'h9 || d_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_first got d=%h v=%b want d=9 v=1", d, d_valid);
    end
    drive(4'hA, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_block cyc=%0d got in_ready=%b want 0", i, in_ready);
      end
      tick();
      n_cmp++;
      if (d !== 4'h9 || d_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got d=%h v=%b want d=9 v=1", i, d, d_valid);
      end
    end
    rdy = 4'hF;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release got in_ready=%b want 1", in_ready);
    end
    tick();
    drive(4'h0, 2'd0, 1'b0);
    n_cmp++;
    if (d !== 4'hA || d_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_second got d=%h v=%b want d=a v=1", d, d_valid);
    end
    tick();
  endtask

  task automatic test_independent();
    rdy = 4'b1101;
    drive(4'h7, 2'd1, 1'b1);
    tick();
    drive(4'h3, 2'd0, 1'b1);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL indep_in_ready got %b want 1", in_ready);
    end
    tick();
    drive(4'h0, 2'd0, 1'b0);
    n_cmp++;
    if (a !== 4'h3 || b !== 4'h7 || out_v !== 4'b0011) begin
      n_fail++;
      $display("FAIL indep got a=%h b=%h valids=%b want a=3 b=7 valids=0011", a, b, out_v);
    end
    rdy = 4'hF;
    tick();
  endtask

  task automatic test_back_to_back();
    rdy = 4'hF;
    for (int i = 0; i < 5; i++) begin
      drive(4'(i + 1), 2'(i % 4), 1'b1);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_in_ready beat=%0d got %b want 1", i, in_ready);
      end
      tick();
      n_cmp++;
      if (out_d[i % 4] !== 4'(i + 1) || out_v !== (4'b0001 << (i % 4))) begin
        n_fail++;
        $display("FAIL b2b beat=%0d got data=%h valids=%b want data=%h valids=%b",
                 i, out_d[i % 4], out_v, 4'(i + 1), 4'b0001 << (i % 4));
      end
    end
    drive(4'h0, 2'd0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    rdy = 4'h0;
    for (int ch = 0; ch < 4; ch++) begin
      drive(4'(ch + 8), 2'(ch), 1'b1);
      tick();
    end
    n_cmp++;
    if (out_v !== 4'b1111 || a !== 4'h8 || d !== 4'hB) begin
      n_fail++;
      $display("FAIL mid_fill got valids=%b a=%h d=%h want 1111 8 b", out_v, a, d);
    end
    rst = 1'b1;
    rdy = 4'hF;
    drive(4'h6, 2'd0, 1'b1);
    tick();
    rst = 1'b0;
    drive(4'h0, 2'd1, 1'b0);
    n_cmp++;
    if (out_v !== 4'b0000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset got valids=%b in_ready=%b want 0000 1", out_v, in_ready);
    end
`ifdef DEMUX4_COUNT_EN
    n_cmp++;
    if ({cnt_a, cnt_b, cnt_c, cnt_d} !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_cnt got %h %h %h %h want 0", cnt_a, cnt_b, cnt_c, cnt_d);
    end
`endif
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      rdy = 4'($urandom_range(0, 15));
      drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      exp_rdy = (exp_q[sel].size() == 0) || rdy[sel];
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_in_ready cyc=%0d got %b want %b", i, in_ready, exp_rdy);
      end
      tick();
      for (int ch = 0; ch < 4; ch++) begin
        n_cmp++;
        if (out_v[ch] !== (exp_q[ch].size() != 0) || out_d[ch] !== last_d[ch]) begin
          n_fail++;
          $display("FAIL rand_out cyc=%0d ch=%0d got v=%b d=%h want v=%b d=%h",
                   i, ch, out_v[ch], out_d[ch], exp_q[ch].size() != 0, last_d[ch]);
        end
`ifdef DEMUX4_COUNT_EN
        n_cmp++;
        if (out_cnt[ch] !== 8'(exp_cnt[ch])) begin
          n_fail++;
          $display("FAIL rand_cnt cyc=%0d ch=%0d got %0d want %0d",
                   i, ch, out_cnt[ch], 8'(exp_cnt[ch]));
        end
`endif
      end
    end
    rst = 1'b0;
  endtask

`ifdef DEMUX4_COUNT_EN
  task automatic test_count_wrap();
    rst = 1'b1;
    drive('0, 2'd0, 1'b0);
    tick();
    rst = 1'b0;
    rdy = 4'hF;
    for (int i = 0; i < 257; i++) begin
      drive(4'($urandom_range(0, 15)), 2'd0, 1'b1);
      tick();
    end
    drive('0, 2'd0, 1'b0);
    n_cmp++;
    if (cnt_a !== 8'd1 || cnt_b !== 8'd0 || cnt_c !== 8'd0 || cnt_d !== 8'd0) begin
      n_fail++;
      $display("FAIL count_wrap got %0d %0d %0d %0d want 1 0 0 0", cnt_a, cnt_b, cnt_c, cnt_d);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    rdy      = 4'hF;
    in_data  = '0;
    sel      = 2'd0;
    in_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_c();
    test_stall_d();
    test_independent();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DEMUX4_COUNT_EN
    test_count_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
